// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read-side flags/data and the downstream valid/ready
// stream used by fifo_stream_reader. The master side is the reader engine;
// the slave side is the FIFO plus the streaming consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);

  // FIFO side
  logic                  fifo_empty;
  logic                  fifo_rd_ok;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_r_en;

  // Stream side
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Delivered-beat counter
  logic [CNT_WIDTH-1:0]  beat_cnt;

  modport master (
    input  fifo_empty,
    input  fifo_rd_ok,
    input  fifo_rdata,
    output fifo_r_en,
    output out_valid,
    input  out_ready,
    output out_data,
    output beat_cnt
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_ok,
    output fifo_rdata,
    input  fifo_r_en,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  beat_cnt
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the synchronous extra-bit-pointer FIFO.
// Requests FIFO reads whenever the 2-entry skid buffer can absorb the data
// (counting reads already in flight), captures the read data one cycle after
// an accepted read, and streams it out on valid/ready at up to one beat per
// cycle. A free-running counter tracks delivered beats.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  r_occ;
  occ_e                  w_occ_next;
  logic                  r_inflight;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [DATA_WIDTH-1:0] r_last;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [2:0]            w_level;

  // Data returns exactly one cycle after an accepted read, so the registered
  // accept strobe is the push. A transfer happens whenever valid meets ready.
  assign w_push = r_inflight;
  assign w_pop  = w_out_valid & bus.out_ready;

  // Entries that will be held next cycle if no new read is issued now:
  // current occupancy plus the read in flight, minus the beat leaving now.
  // Pop only happens with occ >= 1, so this never underflows.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Request only if the FIFO looks non-empty and the buffer has a free slot
  // once everything already committed has landed. A rejected request (stale
  // empty flag) simply never comes back as a push.
  assign bus.fifo_r_en = rst_n & ~bus.fifo_empty & (w_level < 3'd2);

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= EMPTY;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Occupancy next-state: +1 on push, -1 on pop, unchanged when both
  always_comb begin
    w_occ_next = r_occ;
    case (r_occ)
      EMPTY: begin
        if (w_push) begin
          w_occ_next = ONE;
        end
      end
      ONE: begin
        if (w_push && !w_pop) begin
          w_occ_next = TWO;
        end else if (!w_push && w_pop) begin
          w_occ_next = EMPTY;
        end
      end
      TWO: begin
        if (w_pop && !w_push) begin
          w_occ_next = ONE;
        end
      end
      default: w_occ_next = EMPTY;
    endcase
  end

  // Occupancy outputs: the stream is valid whenever anything is buffered
  always_comb begin
    w_out_valid = 1'b0;
    case (r_occ)
      EMPTY:   w_out_valid = 1'b0;
      ONE:     w_out_valid = 1'b1;
      TWO:     w_out_valid = 1'b1;
      default: w_out_valid = 1'b0;
    endcase
  end

  // Track whether a read was accepted last cycle (its data arrives now)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= bus.fifo_rd_ok;
    end
  end

  // Write side of the 2-entry buffer: capture returning FIFO data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else if (w_push) begin
      r_buf[r_wptr] <= bus.fifo_rdata;
      r_wptr        <= ~r_wptr;
    end
  end

  // Read side of the buffer: advance on pop and remember the last beat sent
  // so the data bus does not flip to an older entry once the buffer drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= 1'b0;
      r_last <= '0;
    end else if (w_pop) begin
      r_rptr <= ~r_rptr;
      r_last <= r_buf[r_rptr];
    end
  end

  // Present the buffer head while valid, otherwise hold the last beat
  always_comb begin
    w_out_data = r_last;
    if (w_out_valid) begin
      w_out_data = r_buf[r_rptr];
    end
  end

  // Delivered-beat counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.beat_cnt  = r_beat_cnt;

  // The request rule must make a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_occ == TWO) && !w_pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a queue-based FIFO model feeds the
// reader, a passive recorder logs delivered beats, and each scenario task
// compares the log against the words it loaded.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // FIFO model state
  logic [DW-1:0] fifoQ[$];
  logic          emptyReg  = 1'b1;
  logic [DW-1:0] fifoRdata = '0;
  logic          staleForce = 1'b0;
  logic          outReady   = 1'b0;

  // Recorder state
  logic [DW-1:0] gotQ[$];
  int            popCycles[$];
  int            acceptCnt = 0;
  int            popCnt    = 0;
  int            cycleCnt  = 0;
  int            firstReqCycle = -1;
  bit            overFill  = 1'b0;

  int vecCount = 0;
  int errCount = 0;

  // The FIFO accepts a read only if its own registered empty flag is clear
  assign bus.fifo_empty  = emptyReg & ~staleForce;
  assign bus.fifo_rd_ok  = bus.fifo_r_en & ~emptyReg;
  assign bus.fifo_rdata  = fifoRdata;
  assign bus.out_ready   = outReady;

  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_rd_ok = bus.fifo_rd_ok;
  assign bus4.fifo_rdata = bus.fifo_rdata;
  assign bus4.out_ready  = bus.out_ready;

  // Behavioural FIFO: registered read data, registered empty flag
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifoQ.delete();
      emptyReg  <= 1'b1;
      fifoRdata <= '0;
    end else begin
      if (bus.fifo_rd_ok && fifoQ.size() != 0) begin
        fifoRdata <= fifoQ.pop_front();
      end
      emptyReg <= (fifoQ.size() == 0);
    end
  end

  always @(posedge clk) cycleCnt++;

  // Passive log of accepted reads and delivered beats
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_rd_ok) acceptCnt++;
      if (bus.fifo_r_en && firstReqCycle < 0) firstReqCycle = cycleCnt;
      if (bus.out_valid && bus.out_ready) begin
        gotQ.push_back(bus.out_data);
        popCycles.push_back(cycleCnt);
        popCnt++;
      end
      if (acceptCnt - popCnt > 2) overFill = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] w);
    fifoQ.push_back(w);
  endtask

  task automatic clearLog();
    gotQ.delete();
    popCycles.delete();
    acceptCnt     = 0;
    popCnt        = 0;
    overFill      = 1'b0;
    firstReqCycle = -1;
  endtask

  task automatic doReset();
    tick();
    rst_n      = 1'b0;
    outReady   = 1'b0;
    staleForce = 1'b0;
    clearLog();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    staleForce = 1'b1;
    rst_n      = 1'b0;
    tick();
    tick();
    vecCount++;
    if (bus.fifo_r_en !== 1'b0) begin
      errCount++;
      $display("FAIL reset_r_en: got %0b expected 0", bus.fifo_r_en);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      errCount++;
      $display("FAIL reset_valid: got %0b expected 0", bus.out_valid);
    end
    vecCount++;
    if (bus.out_data !== 8'h00) begin
      errCount++;
      $display("FAIL reset_data: got %0h expected 0", bus.out_data);
    end
    vecCount++;
    if (bus.beat_cnt !== 16'd0) begin
      errCount++;
      $display("FAIL reset_cnt: got %0d expected 0", bus.beat_cnt);
    end
    staleForce = 1'b0;
    clearLog();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    doReset();
    for (int i = 0; i < 8; i++) preload(8'h11 + 8'(i));
    outReady = 1'b1;
    for (int c = 0; c < 40 && gotQ.size() < 8; c++) tick();
    tick();
    tick();
    vecCount++;
    if (gotQ.size() != 8) begin
      errCount++;
      $display("FAIL stream_count: got %0d beats expected 8", gotQ.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vecCount++;
        if (gotQ[i] !== 8'h11 + 8'(i)) begin
          errCount++;
          $display("FAIL stream_data[%0d]: got %0h expected %0h", i, gotQ[i], 8'h11 + 8'(i));
        end
        vecCount++;
        if (popCycles[i] != firstReqCycle + 2 + i) begin
          errCount++;
          $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, popCycles[i], firstReqCycle + 2 + i);
        end
      end
    end
    vecCount++;
    if (bus.beat_cnt !== 16'd8) begin
      errCount++;
      $display("FAIL stream_beat_cnt: got %0d expected 8", bus.beat_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[4];
    doReset();
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      preload(w[i]);
    end
    outReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.out_valid) begin
        vecCount++;
        if (bus.out_data !== w[0]) begin
          errCount++;
          $display("FAIL bp_stable: got %0h expected %0h", bus.out_data, w[0]);
        end
      end
    end
    vecCount++;
    if (acceptCnt != 2) begin
      errCount++;
      $display("FAIL bp_accepts: got %0d expected 2", acceptCnt);
    end
    vecCount++;
    if (bus.fifo_r_en !== 1'b0) begin
      errCount++;
      $display("FAIL bp_r_en: got %0b expected 0", bus.fifo_r_en);
    end
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      errCount++;
      $display("FAIL bp_valid: got %0b expected 1", bus.out_valid);
    end
    outReady = 1'b1;
    for (int c = 0; c < 30 && gotQ.size() < 4; c++) tick();
    repeat (4) tick();
    vecCount++;
    if (gotQ.size() != 4) begin
      errCount++;
      $display("FAIL bp_count: got %0d beats expected 4", gotQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecCount++;
        if (gotQ[i] !== w[i]) begin
          errCount++;
          $display("FAIL bp_data[%0d]: got %0h expected %0h", i, gotQ[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_stale_empty();
    doReset();
    staleForce = 1'b1;
    outReady   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vecCount++;
      if (bus.fifo_r_en !== 1'b1 || bus.out_valid !== 1'b0) begin
        errCount++;
        $display("FAIL stale_cycle%0d: got r_en=%0b valid=%0b expected r_en=1 valid=0",
                 c, bus.fifo_r_en, bus.out_valid);
      end
    end
    vecCount++;
    if (gotQ.size() != 0 || bus.beat_cnt !== 16'd0) begin
      errCount++;
      $display("FAIL stale_beats: got %0d beats cnt=%0d expected 0", gotQ.size(), bus.beat_cnt);
    end
    staleForce = 1'b0;
  endtask

  task automatic test_alternating();
    doReset();
    for (int i = 0; i < 16; i++) preload(8'(i));
    for (int c = 0; c < 120 && gotQ.size() < 16; c++) begin
      outReady = ~outReady;
      tick();
    end
    outReady = 1'b0;
    repeat (3) tick();
    vecCount++;
    if (gotQ.size() != 16) begin
      errCount++;
      $display("FAIL alt_count: got %0d beats expected 16", gotQ.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vecCount++;
        if (gotQ[i] !== 8'(i)) begin
          errCount++;
          $display("FAIL alt_data[%0d]: got %0h expected %0h", i, gotQ[i], i);
        end
      end
    end
    vecCount++;
    if (bus.beat_cnt !== 16'd16) begin
      errCount++;
      $display("FAIL alt_beat_cnt: got %0d expected 16", bus.beat_cnt);
    end
    vecCount++;
    if (overFill) begin
      errCount++;
      $display("FAIL alt_held: got more than 2 outstanding expected at most 2");
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] b[3];
    doReset();
    for (int i = 0; i < 8; i++) preload(8'($urandom));
    outReady = 1'b1;
    repeat (5) tick();
    outReady = 1'b0;
    tick();
    vecCount++;
    if (bus.out_valid !== 1'b1) begin
      errCount++;
      $display("FAIL midrst_pre_valid: got %0b expected 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (bus.fifo_r_en !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.beat_cnt !== 16'd0) begin
      errCount++;
      $display("FAIL midrst_outputs: got r_en=%0b valid=%0b data=%0h cnt=%0d expected all 0",
               bus.fifo_r_en, bus.out_valid, bus.out_data, bus.beat_cnt);
    end
    clearLog();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      preload(b[i]);
    end
    outReady = 1'b1;
    for (int c = 0; c < 30 && gotQ.size() < 3; c++) tick();
    repeat (4) tick();
    vecCount++;
    if (gotQ.size() != 3) begin
      errCount++;
      $display("FAIL midrst_count: got %0d beats expected 3", gotQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecCount++;
        if (gotQ[i] !== b[i]) begin
          errCount++;
          $display("FAIL midrst_data[%0d]: got %0h expected %0h", i, gotQ[i], b[i]);
        end
      end
    end
    vecCount++;
    if (bus.beat_cnt !== 16'd3) begin
      errCount++;
      $display("FAIL midrst_beat_cnt: got %0d expected 3", bus.beat_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    logic [DW-1:0] w[17];
    doReset();
    for (int i = 0; i < 17; i++) begin
      w[i] = 8'($urandom);
      preload(w[i]);
    end
    outReady = 1'b1;
    for (int c = 0; c < 60 && gotQ.size() < 17; c++) tick();
    repeat (3) tick();
    vecCount++;
    if (bus4.beat_cnt !== 4'd1) begin
      errCount++;
      $display("FAIL wrap_cnt4: got %0d expected 1", bus4.beat_cnt);
    end
    vecCount++;
    if (bus.beat_cnt !== 16'd17) begin
      errCount++;
      $display("FAIL wrap_cnt16: got %0d expected 17", bus.beat_cnt);
    end
    vecCount++;
    if (gotQ.size() != 17) begin
      errCount++;
      $display("FAIL wrap_count: got %0d beats expected 17", gotQ.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        vecCount++;
        if (gotQ[i] !== w[i]) begin
          errCount++;
          $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, gotQ[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    int n;
    doReset();
    for (int c = 0; c < 2000 && gotQ.size() < 40; c++) begin
      if (sent.size() < 40 && $urandom_range(0, 2) != 0) begin
        sent.push_back(8'($urandom));
        preload(sent[sent.size()-1]);
      end
      outReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    outReady = 1'b0;
    repeat (3) tick();
    n = gotQ.size();
    vecCount++;
    if (n != 40) begin
      errCount++;
      $display("FAIL rand_count: got %0d beats expected 40", n);
    end
    for (int i = 0; i < n && i < sent.size(); i++) begin
      vecCount++;
      if (gotQ[i] !== sent[i]) begin
        errCount++;
        $display("FAIL rand_data[%0d]: got %0h expected %0h", i, gotQ[i], sent[i]);
      end
    end
    vecCount++;
    if (bus.beat_cnt !== 16'(n) || bus4.beat_cnt !== 4'(n)) begin
      errCount++;
      $display("FAIL rand_beat_cnt: got %0d/%0d expected %0d/%0d",
               bus.beat_cnt, bus4.beat_cnt, n, n % 16);
    end
    vecCount++;
    if (overFill) begin
      errCount++;
      $display("FAIL rand_held: got more than 2 outstanding expected at most 2");
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stale_empty();
    test_alternating();
    test_mid_reset();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the synchronous extra-bit-pointer FIFO. It issues FIFO read requests from the FIFO's `empty` flag and the accepted-read strobe (`cr_en`). It captures read data, which returns one cycle after an accepted read, into a 2-entry output buffer. It presents that data downstream on a valid/ready stream at one beat per cycle with no drops or duplicates. It sits between the FIFO flags/memory and any streaming consumer, and keeps a running count of delivered beats.

## Interface
- `DATA_WIDTH`, 8, width of the FIFO read data and stream data.
- `CNT_WIDTH`, 16, width of the delivered-beat counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `fifo_empty`  in  1  registered FIFO empty flag (reset value 1 at the FIFO); may lag the true state by one cycle.
- `fifo_rd_ok`  in  1  FIFO accepted-read strobe (`cr_en`), same cycle as `fifo_r_en`.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_ok`=1.
- `fifo_r_en`  out  1  read request to the FIFO.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  DATA_WIDTH  stream data (head of buffer).
- `beat_cnt`  out  CNT_WIDTH  number of beats transferred (`out_valid & out_ready`), wraps modulo 2^CNT_WIDTH.

## Operation
- **State**
  - `occ` is the buffer occupancy, 0..2, with states EMPTY, ONE and TWO.
  - `inflight` is the registered `fifo_rd_ok`.
  - The buffer holds 2 entries and is written at `wptr` and read at `rptr`. Both pointers are 1 bit and wrap 1→0.
- **Pop:** `pop = out_valid & out_ready`.
  - `out_valid = (occ != 0)`.
  - `out_data = buf[rptr]`. It is 0 when `occ`=0 after reset and holds its last value otherwise.
- **Push:** `push = inflight`. On push, `fifo_rdata` is written to `buf[wptr]` and `wptr` toggles.
- **Request rule:** `fifo_r_en = !fifo_empty & (occ + inflight - pop < 2)`.
  - The sum is computed in 3 bits.
  - `fifo_r_en` is combinational from registered state, `fifo_empty` and `out_ready`.
- **Credit:** a request not accepted (`fifo_rd_ok`=0) costs no credit and returns no data. This covers the stale-`empty` case: the reader issues the request and the FIFO gates it.
- **Occupancy update:** `occ_next = occ + push - pop`.
  - Push and pop in the same cycle leave `occ` unchanged. Both pointers advance.
  - The request rule guarantees `occ_next` ≤ 2. A push with `occ`=2 and no pop is an assertion failure.
- **Counter:** `beat_cnt` increments by 1 on every pop and wraps from all-ones to 0.

## Timing
- **Reset** (`rst_n`=0, asynchronous): `occ`=0, `inflight`=0, `wptr`=`rptr`=0, `out_valid`=0, `out_data`=0, `beat_cnt`=0. `fifo_r_en` is forced 0 while `rst_n`=0.
- **Reset mid-operation:** buffered and in-flight data are discarded with no drain. The FIFO is reset by the same `rst_n`.
- **Latency:**
  - `fifo_r_en`/`fifo_rd_ok` at cycle N, `fifo_rdata` sampled at edge N+1, `out_valid`=1 in cycle N+2.
  - The minimum FIFO-to-stream latency is 2 cycles.
- **Throughput:**
  - With `out_ready` held 1 and the FIFO non-empty, one beat is delivered every cycle after the initial fill.
  - Steady state is `occ`=1 and `inflight`=1.
- **Backpressure:**
  - With `out_ready`=0, at most 2 beats are held and `fifo_r_en` deasserts once `occ + inflight` = 2.
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- **Empty edge:** when `fifo_empty` rises, `fifo_r_en` drops the same cycle. Data already in flight is still delivered.

## Test plan
- **Reset values:** hold `rst_n`=0 with `fifo_empty`=0 → `fifo_r_en`=0, `out_valid`=0, `out_data`=0, `beat_cnt`=0.
- **Streaming:**
  - Stimulus: preload FIFO with 0x11..0x18 (8 words), `out_ready`=1.
  - Required: `out_data` sequence 0x11..0x18 on 8 consecutive cycles starting 2 cycles after the first `fifo_r_en`, and `beat_cnt`=8.
- **Backpressure:**
  - Stimulus: 4 words in the FIFO, `out_ready`=0 for 10 cycles.
  - Required: exactly 2 accepted reads, `fifo_r_en`=0 thereafter, `out_data`=first word stable.
  - Then raise `out_ready`: all 4 words in order, no duplicates.
- **Stale empty:**
  - Stimulus: `fifo_empty`=0 with `fifo_rd_ok`=0 on a request cycle.
  - Required: no push next cycle, `occ` unchanged, no spurious beat.
- **Alternating ready:**
  - Stimulus: toggle `out_ready` 1/0 every cycle over 16 words 0x00..0x0F.
  - Required: in-order delivery of 0x00..0x0F, `beat_cnt`=16, `occ` never exceeds 2.
- **Mid-operation reset and counter wrap:**
  - Assert `rst_n`=0 with `occ`=2 and `inflight`=1 → all outputs return to reset values immediately, and after release no stale data appears.
  - With CNT_WIDTH=4, 17 beats → `beat_cnt`=1.
